// File: rtl/grid_renderer.sv
// grid_renderer: N x N board renderer on the VGA pixel path, 3-stage output pipeline.
// Define GRID_CURSOR_EN to build the blinking cursor outline (cursor ports are ignored otherwise).
module grid_renderer #(
  parameter int GRID_N       = 3,
  parameter int CELL         = 40,
  parameter int GAP          = 10,
  parameter int H_OFF        = 230,
  parameter int V_OFF        = 150,
  parameter int RADIUS       = 15,
  parameter int LINE_W       = 3,
  parameter int BLINK_FRAMES = 30
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [9:0]                          x_pos,
  input  logic [9:0]                          y_pos,
  input  logic                                pix_valid,
  input  logic [GRID_N*GRID_N-1:0]            cell_p1,
  input  logic [GRID_N*GRID_N-1:0]            cell_p2,
  input  logic [GRID_N*GRID_N-1:0]            win_mask,
  input  logic [$clog2(GRID_N*GRID_N)-1:0]    cursor_idx,
  input  logic                                cursor_en,
  output logic [7:0]                          red,
  output logic [7:0]                          green,
  output logic [7:0]                          blue,
  output logic                                rgb_valid
);
  localparam int NC    = GRID_N * GRID_N;
  localparam int IW    = $clog2(NC);
  localparam int PITCH = CELL + GAP;
  localparam int BOARD = GRID_N * CELL + (GRID_N - 1) * GAP;
  localparam int FW    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [24:0] R2 = 25'(RADIUS * RADIUS);

  typedef struct packed {
    logic               line, p1, p2, win, cur;
    logic signed [11:0] dx, dy;
  } s1_t;

  typedef struct packed {
    logic        line, p1, p2, win, cur;
    logic [23:0] dx2, dy2;
  } s2_t;

  logic [NC-1:0] p1_q, p1_d, p2_q, p2_d, win_q, win_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_q, blink_d, frame_start;
  logic [2:0]    vld_pipe_q, vld_pipe_d;
  s1_t           s1_q, s1_d;
  s2_t           s2_q, s2_d;
  logic [23:0]   rgb_q, rgb_d;

  // The next-state shadows feed S1 so the frame-start pixel already sees the new frame's board.
  always_comb begin
    frame_start = pix_valid && x_pos == '0 && y_pos == '0;
    p1_d        = p1_q;
    p2_d        = p2_q;
    win_d       = win_q;
    frame_cnt_d = frame_cnt_q;
    blink_d     = blink_q;
    if (frame_start) begin
      p1_d  = cell_p1;
      p2_d  = cell_p2;
      win_d = win_mask;
      if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
        frame_cnt_d = '0;
        blink_d     = ~blink_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  logic [11:0]   xe, ye, x_off, y_off;
  logic [3:0]    col, row;
  logic [IW-1:0] idx;
  logic          in_x, in_y, in_cell, vl, hl, x_in_board, y_in_board, edge_px, line, cur_hit;
  logic signed [11:0] dx, dy;

  always_comb begin
    xe    = {2'b00, x_pos};
    ye    = {2'b00, y_pos};
    in_x  = 1'b0;
    in_y  = 1'b0;
    col   = '0;
    row   = '0;
    x_off = '0;
    y_off = '0;
    vl    = 1'b0;
    hl    = 1'b0;
    for (int i = 0; i < GRID_N; i++) begin
      if (xe >= 12'(H_OFF + i * PITCH) && xe <= 12'(H_OFF + i * PITCH + CELL - 1)) begin
        in_x  = 1'b1;
        col   = 4'(i);
        x_off = xe - 12'(H_OFF + i * PITCH);
      end
      if (ye >= 12'(V_OFF + i * PITCH) && ye <= 12'(V_OFF + i * PITCH + CELL - 1)) begin
        in_y  = 1'b1;
        row   = 4'(i);
        y_off = ye - 12'(V_OFF + i * PITCH);
      end
    end
    for (int k = 1; k < GRID_N; k++) begin
      if (xe >= 12'(H_OFF + k * PITCH) && xe <= 12'(H_OFF + k * PITCH + LINE_W - 1)) vl = 1'b1;
      if (ye >= 12'(V_OFF + k * PITCH) && ye <= 12'(V_OFF + k * PITCH + LINE_W - 1)) hl = 1'b1;
    end
    x_in_board = xe >= 12'(H_OFF) && xe <= 12'(H_OFF + BOARD);
    y_in_board = ye >= 12'(V_OFF) && ye <= 12'(V_OFF + BOARD);
    line       = (vl && y_in_board) || (hl && x_in_board);
    in_cell    = in_x && in_y;
    idx        = in_cell ? IW'(row * GRID_N + col) : '0;
    edge_px    = x_off <= 12'd2 || x_off >= 12'(CELL - 3) ||
                 y_off <= 12'd2 || y_off >= 12'(CELL - 3);
    dx         = $signed(xe - 12'(H_OFF + col * PITCH + CELL / 2));
    dy         = $signed(ye - 12'(V_OFF + row * PITCH + CELL / 2));
  end

`ifdef GRID_CURSOR_EN
  logic [IW-1:0] cur_idx_q, cur_idx_d;
  logic          cur_en_q, cur_en_d;

  always_comb begin
    cur_idx_d = cur_idx_q;
    cur_en_d  = cur_en_q;
    if (frame_start) begin
      cur_idx_d = cursor_idx;
      cur_en_d  = cursor_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_idx_q <= '0;
      cur_en_q  <= 1'b0;
    end else begin
      cur_idx_q <= cur_idx_d;
      cur_en_q  <= cur_en_d;
    end
  end

  // idx only ever holds a real cell number, so an out-of-range cursor never matches.
  assign cur_hit = cur_en_d && blink_d && in_cell && edge_px && idx == cur_idx_d;
`else
  logic cursor_unused;
  assign cursor_unused = ^{cursor_idx, cursor_en, edge_px};
  assign cur_hit       = 1'b0;
`endif

  logic signed [23:0] dx_sq, dy_sq;
  logic [24:0]        sq_sum;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[1:0], pix_valid};
    s1_d.line  = line;
    s1_d.p1    = in_cell && p1_d[idx];
    s1_d.p2    = in_cell && p2_d[idx];
    s1_d.win   = in_cell && win_d[idx] && blink_d;
    s1_d.cur   = cur_hit;
    s1_d.dx    = dx;
    s1_d.dy    = dy;

    dx_sq     = s1_q.dx * s1_q.dx;
    dy_sq     = s1_q.dy * s1_q.dy;
    s2_d.line = s1_q.line;
    s2_d.p1   = s1_q.p1;
    s2_d.p2   = s1_q.p2;
    s2_d.win  = s1_q.win;
    s2_d.cur  = s1_q.cur;
    s2_d.dx2  = $unsigned(dx_sq);
    s2_d.dy2  = $unsigned(dy_sq);

    sq_sum = {1'b0, s2_q.dx2} + {1'b0, s2_q.dy2};
    rgb_d  = 24'h000000;
    if (!vld_pipe_q[1])                   rgb_d = 24'h000000;
    else if (s2_q.cur)                    rgb_d = 24'hFFFF00;
    else if (sq_sum <= R2 && s2_q.win)    rgb_d = 24'hFFFFFF;
    else if (sq_sum <= R2 && s2_q.p1)     rgb_d = 24'hFF0000;
    else if (sq_sum <= R2 && s2_q.p2)     rgb_d = 24'h00FF00;
    else if (s2_q.line)                   rgb_d = 24'h0000FF;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1_q        <= '0;
      p2_q        <= '0;
      win_q       <= '0;
      frame_cnt_q <= '0;
      blink_q     <= 1'b1;
      vld_pipe_q  <= '0;
      s1_q        <= '0;
      s2_q        <= '0;
      rgb_q       <= '0;
    end else begin
      p1_q        <= p1_d;
      p2_q        <= p2_d;
      win_q       <= win_d;
      frame_cnt_q <= frame_cnt_d;
      blink_q     <= blink_d;
      vld_pipe_q  <= vld_pipe_d;
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      rgb_q       <= rgb_d;
    end
  end

  assign {red, green, blue} = rgb_q;
  assign rgb_valid          = vld_pipe_q[2];
endmodule

// File: tb/tb_grid_renderer.sv
// Directed bench for grid_renderer: default board plus a 4x4 instance sharing the pixel stream.
module tb_grid_renderer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  x_pos = '0, y_pos = '0;
  logic        pix_valid = 1'b0;
  logic [8:0]  cell_p1 = '0, cell_p2 = '0, win_mask = '0;
  logic [3:0]  cursor_idx = '0;
  logic        cursor_en = 1'b0;
  logic [7:0]  red, green, blue;
  logic        rgb_valid;
  logic [15:0] p1_g = '0, p2_g = '0, win_g = '0;
  logic [3:0]  cur_g = '0;
  logic [7:0]  red_g, green_g, blue_g;
  logic        vld_g;
  int          checks = 0, errors = 0, nframes = 0;

`ifdef GRID_CURSOR_EN
  localparam bit CUR_BUILT = 1'b1;
`else
  localparam bit CUR_BUILT = 1'b0;
`endif

  always #5 clk = ~clk;

  grid_renderer dut (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .pix_valid(pix_valid),
    .cell_p1(cell_p1), .cell_p2(cell_p2), .win_mask(win_mask),
    .cursor_idx(cursor_idx), .cursor_en(cursor_en),
    .red(red), .green(green), .blue(blue), .rgb_valid(rgb_valid)
  );

  grid_renderer #(.GRID_N(4), .CELL(20), .GAP(4), .H_OFF(0), .V_OFF(0), .RADIUS(8)) dut_g (
    .clk(clk), .rst(rst), .x_pos(x_pos), .y_pos(y_pos), .pix_valid(pix_valid),
    .cell_p1(p1_g), .cell_p2(p2_g), .win_mask(win_g),
    .cursor_idx(cur_g), .cursor_en(1'b0),
    .red(red_g), .green(green_g), .blue(blue_g), .rgb_valid(vld_g)
  );

  // Presents one pixel for one clock and returns #1 after the edge that registers its colour.
  task automatic send_pix(input logic [9:0] x, input logic [9:0] y, input logic v);
    @(negedge clk);
    x_pos = x; y_pos = y; pix_valid = v;
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic do_frame();
    @(negedge clk);
    x_pos = '0; y_pos = '0; pix_valid = 1'b1;
    @(negedge clk);
    pix_valid = 1'b0;
    nframes++;
  endtask

  function automatic bit blink_model();
    return ((nframes / 30) % 2) == 0;
  endfunction

  task automatic test_reset();
    x_pos = 10'd250; y_pos = 10'd170; pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb_valid, red, green, blue} !== 25'h0) begin
      errors++;
      $display("FAIL reset_state: got %h expected 0", {rgb_valid, red, green, blue});
    end
    @(negedge clk);
    rst = 1'b0; pix_valid = 1'b0;
  endtask

  task automatic test_latency();
    @(negedge clk);
    x_pos = 10'd290; y_pos = 10'd200; pix_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pix_valid = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (rgb_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early: rgb_valid got %b expected 0", rgb_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({rgb_valid, red, green, blue} !== {1'b1, 24'h0000FF}) begin
      errors++;
      $display("FAIL latency_3: got %h expected 10000ff", {rgb_valid, red, green, blue});
    end
  endtask

  task automatic test_lines_p1();
    logic [9:0]  xs [12] = '{250, 280, 275, 265, 266, 250, 250, 200, 290, 370, 371, 250};
    logic [9:0]  ys [12] = '{170, 170, 170, 170, 170, 155, 154, 170, 200, 200, 200, 170};
    logic        vs [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [23:0] es [12] = '{24'hFF0000, 24'h0000FF, 24'h000000, 24'hFF0000, 24'h000000,
                             24'hFF0000, 24'h000000, 24'h000000, 24'h0000FF, 24'h0000FF,
                             24'h000000, 24'h000000};
    cell_p1 = 9'b000000001;
    do_frame();
    for (int i = 0; i < 12; i++) begin
      send_pix(xs[i], ys[i], vs[i]);
      checks++;
      if ({rgb_valid, red, green, blue} !== {vs[i], es[i]}) begin
        errors++;
        $display("FAIL lines_p1[%0d] (%0d,%0d): got %h expected %h", i, xs[i], ys[i],
                 {rgb_valid, red, green, blue}, {vs[i], es[i]});
      end
    end
  endtask

  task automatic test_priority_latch();
    logic [9:0]  xs [6] = '{300, 350, 350, 300, 350, 300};
    logic [9:0]  ys [6] = '{220, 220, 270, 220, 270, 220};
    logic [23:0] es [6] = '{24'hFF0000, 24'h00FF00, 24'h000000, 24'hFF0000,
                            24'h00FF00, 24'h00FF00};
    cell_p1 = 9'b000010000;
    cell_p2 = 9'b000110000;
    do_frame();
    for (int i = 0; i < 6; i++) begin
      if (i == 2) begin
        cell_p1 = 9'b000000000;
        cell_p2 = 9'b100110000;
      end
      if (i == 4) do_frame();
      send_pix(xs[i], ys[i], 1'b1);
      checks++;
      if ({rgb_valid, red, green, blue} !== {1'b1, es[i]}) begin
        errors++;
        $display("FAIL priority_latch[%0d] (%0d,%0d): got %h expected %h", i, xs[i], ys[i],
                 {rgb_valid, red, green, blue}, {1'b1, es[i]});
      end
    end
  endtask

  task automatic test_win_blink();
    logic [23:0] exp;
    cell_p1 = 9'b000000111; cell_p2 = '0; win_mask = 9'b000000111;
    while (nframes < 62) begin
      do_frame();
      send_pix(10'd250, 10'd170, 1'b1);
      exp = blink_model() ? 24'hFFFFFF : 24'hFF0000;
      checks++;
      if ({red, green, blue} !== exp) begin
        errors++;
        $display("FAIL win_blink frame %0d: got %h expected %h", nframes, {red, green, blue}, exp);
      end
    end
  endtask

  task automatic test_cursor();
    logic [3:0]  ci [5] = '{4, 4, 9, 5, 5};
    logic        ce [5] = '{1, 1, 1, 1, 0};
    logic [9:0]  xs [5] = '{318, 305, 318, 368, 368};
    logic [9:0]  ys [5] = '{220, 225, 220, 220, 220};
    logic        hit[5] = '{1, 0, 0, 1, 0};
    logic [23:0] exp;
    bit          b0;
    cell_p1 = '0; cell_p2 = '0; win_mask = '0;
    for (int i = 0; i < 5; i++) begin
      cursor_idx = ci[i]; cursor_en = ce[i];
      do_frame();
      send_pix(xs[i], ys[i], 1'b1);
      exp = (hit[i] && CUR_BUILT && blink_model()) ? 24'hFFFF00 : 24'h000000;
      checks++;
      if ({red, green, blue} !== exp) begin
        errors++;
        $display("FAIL cursor[%0d] idx %0d (%0d,%0d): got %h expected %h", i, ci[i], xs[i],
                 ys[i], {red, green, blue}, exp);
      end
    end
    cursor_idx = 4'd4; cursor_en = 1'b1;
    b0 = blink_model();
    for (int n = 0; n < 31 && blink_model() == b0; n++) do_frame();
    send_pix(10'd318, 10'd220, 1'b1);
    exp = (CUR_BUILT && blink_model()) ? 24'hFFFF00 : 24'h000000;
    checks++;
    if ({red, green, blue} !== exp) begin
      errors++;
      $display("FAIL cursor_phase frame %0d: got %h expected %h", nframes, {red, green, blue}, exp);
    end
  endtask

  task automatic test_geometry();
    logic [9:0]  xs [7] = '{82, 24, 90, 91, 92, 93, 82};
    logic [9:0]  ys [7] = '{82, 50, 82, 82, 50, 50, 82};
    logic        vs [7] = '{1, 1, 1, 1, 1, 1, 0};
    logic [23:0] es [7] = '{24'h00FF00, 24'h0000FF, 24'h00FF00, 24'h000000,
                            24'h0000FF, 24'h000000, 24'h000000};
    p2_g = 16'h8000;
    do_frame();
    for (int i = 0; i < 7; i++) begin
      send_pix(xs[i], ys[i], vs[i]);
      checks++;
      if ({vld_g, red_g, green_g, blue_g} !== {vs[i], es[i]}) begin
        errors++;
        $display("FAIL geometry[%0d] (%0d,%0d): got %h expected %h", i, xs[i], ys[i],
                 {vld_g, red_g, green_g, blue_g}, {vs[i], es[i]});
      end
    end
  endtask

  task automatic test_reset_mid();
    cursor_en = 1'b0; cell_p1 = 9'b000000001; cell_p2 = '0; win_mask = '0;
    do_frame();
    @(negedge clk);
    x_pos = 10'd250; y_pos = 10'd170; pix_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({rgb_valid, red, green, blue} !== {1'b1, 24'hFF0000}) begin
      errors++;
      $display("FAIL pre_reset: got %h expected 1ff0000", {rgb_valid, red, green, blue});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({rgb_valid, red, green, blue} !== 25'h0) begin
      errors++;
      $display("FAIL async_reset: got %h expected 0", {rgb_valid, red, green, blue});
    end
    @(negedge clk);
    pix_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    nframes = 0;
    send_pix(10'd250, 10'd170, 1'b1);
    checks++;
    if ({rgb_valid, red, green, blue} !== {1'b1, 24'h000000}) begin
      errors++;
      $display("FAIL zero_shadow: got %h expected 1000000", {rgb_valid, red, green, blue});
    end
    do_frame();
    send_pix(10'd250, 10'd170, 1'b1);
    checks++;
    if ({rgb_valid, red, green, blue} !== {1'b1, 24'hFF0000}) begin
      errors++;
      $display("FAIL reload_after_reset: got %h expected 1ff0000", {rgb_valid, red, green, blue});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency();
    test_lines_p1();
    test_priority_latch();
    test_win_blink();
    test_cursor();
    test_geometry();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
